// File: rtl/nn_layer_fwd_if.sv
// Bus bundle for nn_layer_fwd: run control, input/weight memory ports,
// external sigmoid LUT and the valid/ready output stream.
interface nn_layer_fwd_if #(
  parameter int N_IN  = 784,
  parameter int N_SMP = 40,
  parameter int DW    = 8,
  parameter int WW    = 12
) ();
  localparam int XAW = (N_IN * N_SMP > 1) ? $clog2(N_IN * N_SMP) : 1;
  localparam int WAW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CW  = (N_SMP > 1) ? $clog2(N_SMP) : 1;

  logic           start;
  logic           busy;
  logic           done;
  logic [XAW-1:0] x_addr;
  logic           x_rd;
  logic [DW-1:0]  x_data;
  logic [WAW-1:0] w_addr;
  logic           w_rd;
  logic [WW-1:0]  w_data;
  logic [10:0]    sig_in;
  logic [7:0]     sig_out;
  logic           y_valid;
  logic [9:0]     y_data;
  logic [CW-1:0]  y_idx;
  logic           y_ready;

  modport master (
    input  start, x_data, w_data, sig_out, y_ready,
    output busy, done, x_addr, x_rd, w_addr, w_rd, sig_in, y_valid, y_data, y_idx
  );

  modport slave (
    output start, x_data, w_data, sig_out, y_ready,
    input  busy, done, x_addr, x_rd, w_addr, w_rd, sig_in, y_valid, y_data, y_idx
  );
endinterface

// File: rtl/nn_layer_fwd.sv
// Single-neuron forward pass: per sample, a saturating dot product of N_IN
// unsigned pixels with shared signed weights, then sigmoid or clamped linear.
module nn_layer_fwd #(
  parameter int N_IN   = 784,
  parameter int N_SMP  = 40,
  parameter int DW     = 8,
  parameter int WW     = 12,
  parameter int ACC_W  = 32,
  parameter int FRAC   = 16,
  parameter int ACT_EN = 1
) (
  input logic          clk,
  input logic          rst,
  nn_layer_fwd_if.master bus
);
  localparam int XAW = (N_IN * N_SMP > 1) ? $clog2(N_IN * N_SMP) : 1;
  localparam int WAW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CW  = (N_SMP > 1) ? $clog2(N_SMP) : 1;
  localparam int PW  = DW + WW + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] ACT   = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic signed [ACC_W:0]   SMAX_X  = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   SMIN_X  = -SMAX_X;
  localparam logic signed [ACC_W-1:0] LIN_MAX = ACC_W'(256);

  logic [2:0]     state_q, state_d;
  logic [WAW-1:0] i_q, i_d;
  logic [CW-1:0]  c_q, c_d;
  logic [XAW-1:0] base_q, base_d;
  logic           rd, rd_q, first_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic           sat_q, sat_d;
  logic [9:0]     y_q;

  // ---------------------------------------------------------------- control
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    c_d     = c_q;
    base_d  = base_q;
    rd      = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = FETCH;
        i_d     = '0;
        c_d     = '0;
        base_d  = '0;
      end
      FETCH: begin
        rd = 1'b1;
        if (i_q == WAW'(N_IN - 1)) begin
          state_d = DRAIN;
          i_d     = '0;
        end else begin
          i_d = i_q + WAW'(1);
        end
      end
      DRAIN: state_d = ACT;
      ACT:   state_d = OUT;
      OUT: if (bus.y_ready) begin
        if (c_q == CW'(N_SMP - 1)) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
          c_d     = c_q + CW'(1);
          base_d  = base_q + XAW'(N_IN);
          i_d     = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------- datapath
  logic signed [PW-1:0]  xs, ws, prod;
  logic signed [ACC_W:0] prod_x, base_x, sum;

  assign xs     = {{(PW-DW){1'b0}}, bus.x_data};
  assign ws     = {{(PW-WW){bus.w_data[WW-1]}}, bus.w_data};
  assign prod   = xs * ws;
  assign prod_x = {{(ACC_W+1-PW){prod[PW-1]}}, prod};
  assign base_x = first_q ? '0 : {acc_q[ACC_W-1], acc_q};
  assign sum    = base_x + prod_x;

  // Once clamped, the accumulator ignores further products of this sample.
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (first_q || !sat_q) begin
      sat_d = 1'b0;
      if (sum > SMAX_X) begin
        acc_d = SMAX_X[ACC_W-1:0];
        sat_d = 1'b1;
      end else if (sum < SMIN_X) begin
        acc_d = SMIN_X[ACC_W-1:0];
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  // ----------------------------------------------------------- activation
  logic                    neg, big;
  logic [ACC_W-1:0]        zabs;
  logic signed [ACC_W-1:0] zsh;
  logic [9:0]              y_sig, y_lin, y_nxt;

  assign neg  = acc_q[ACC_W-1];
  assign zabs = neg ? -acc_q : acc_q;
  assign big  = |zabs[ACC_W-1:FRAC+3];
  assign zsh  = acc_q >>> (FRAC - 8);

  always_comb begin
    if (big)      y_sig = neg ? 10'd0 : 10'd256;
    else if (neg) y_sig = 10'd256 - {2'b00, bus.sig_out};
    else          y_sig = {2'b00, bus.sig_out};
    if (neg)                y_lin = 10'd0;
    else if (zsh > LIN_MAX) y_lin = 10'd256;
    else                    y_lin = zsh[9:0];
    y_nxt = (ACT_EN != 0) ? y_sig : y_lin;
  end

  if (FRAC > 8) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^zabs[FRAC-9:0];
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      c_q     <= '0;
      base_q  <= '0;
      rd_q    <= 1'b0;
      first_q <= 1'b0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      c_q     <= c_d;
      base_q  <= base_d;
      rd_q    <= rd;
      first_q <= rd && (i_q == '0);
      if (state_q == IDLE && bus.start) begin
        acc_q <= '0;
        sat_q <= 1'b0;
      end else if (rd_q) begin
        acc_q <= acc_d;
        sat_q <= sat_d;
      end
      if (state_q == ACT) y_q <= y_nxt;
    end
  end

  // -------------------------------------------------------------- outputs
  assign bus.busy    = (state_q == FETCH) || (state_q == DRAIN) ||
                       (state_q == ACT)   || (state_q == OUT);
  assign bus.done    = (state_q == DONE);
  assign bus.x_rd    = rd;
  assign bus.w_rd    = rd;
  assign bus.x_addr  = base_q + XAW'(i_q);
  assign bus.w_addr  = i_q;
  assign bus.sig_in  = zabs[FRAC+2:FRAC-8];
  assign bus.y_valid = (state_q == OUT);
  assign bus.y_data  = y_q;
  assign bus.y_idx   = c_q;
endmodule

// File: tb/tb_nn_layer_fwd.sv
// Bench for nn_layer_fwd: a sigmoid-mode and a linear-mode instance driven
// by directed and $urandom data, checked against a plain-arithmetic model.
module tb_nn_layer_fwd;
  localparam int NI0 = 6, NS0 = 5, NI1 = 4, NS1 = 3;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  nn_layer_fwd_if #(.N_IN(NI0), .N_SMP(NS0), .DW(8), .WW(12)) b0 ();
  nn_layer_fwd_if #(.N_IN(NI1), .N_SMP(NS1), .DW(8), .WW(12)) b1 ();

  nn_layer_fwd #(.N_IN(NI0), .N_SMP(NS0), .DW(8), .WW(12), .ACC_W(32),
                 .FRAC(16), .ACT_EN(1))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  nn_layer_fwd #(.N_IN(NI1), .N_SMP(NS1), .DW(8), .WW(12), .ACC_W(20),
                 .FRAC(16), .ACT_EN(0))
    u1 (.clk(clk), .rst(rst), .bus(b1));

  int xm[2][32];
  int wm[2][8];
  int n_vec = 0, n_err = 0;

  logic       start_s[2], rdy_s[2];
  logic       bsy[2], dn[2], yv[2], xrd[2];
  logic [9:0] yd[2];
  logic [7:0] yi[2];

  function automatic logic [7:0] lut(input logic [10:0] a);
    int v;
    v = 128 + int'(a) / 16;
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  assign b0.start = start_s[0];  assign b1.start = start_s[1];
  assign b0.y_ready = rdy_s[0];  assign b1.y_ready = rdy_s[1];
  assign b0.sig_out = lut(b0.sig_in);
  assign b1.sig_out = lut(b1.sig_in);
  assign bsy[0] = b0.busy;     assign bsy[1] = b1.busy;
  assign dn[0]  = b0.done;     assign dn[1]  = b1.done;
  assign yv[0]  = b0.y_valid;  assign yv[1]  = b1.y_valid;
  assign xrd[0] = b0.x_rd;     assign xrd[1] = b1.x_rd;
  assign yd[0]  = b0.y_data;   assign yd[1]  = b1.y_data;
  assign yi[0]  = 8'(b0.y_idx); assign yi[1] = 8'(b1.y_idx);

  // Synchronous-read memories: data one cycle after the read enable.
  always @(posedge clk) begin
    if (b0.x_rd) b0.x_data <= 8'(xm[0][b0.x_addr]);
    if (b0.w_rd) b0.w_data <= 12'(wm[0][b0.w_addr]);
    if (b1.x_rd) b1.x_data <= 8'(xm[1][b1.x_addr]);
    if (b1.w_rd) b1.w_data <= 12'(wm[1][b1.w_addr]);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: z = saturating sum of x*w in Q.16, then activation.
  function automatic int model_y(input int d, input int c);
    int     nin, accw;
    longint z, mx, p, a;
    bit     sat;
    int     v;
    nin  = d ? NI1 : NI0;
    accw = d ? 20 : 32;
    mx   = (longint'(1) << (accw - 1)) - 1;
    z = 0; sat = 0;
    for (int i = 0; i < nin; i++) begin
      p = longint'(xm[d][c*nin + i]) * longint'(wm[d][i]);
      if (!sat) begin
        z = z + p;
        if (z > mx)  begin z = mx;  sat = 1; end
        if (z < -mx) begin z = -mx; sat = 1; end
      end
    end
    if (d == 0) begin
      if (z >= (longint'(1) << 19)) return 256;
      if (z <= -(longint'(1) << 19)) return 0;
      a = (z < 0) ? -z : z;
      v = int'(lut(11'(a / 256)));
      return (z < 0) ? 256 - v : v;
    end
    z = z >>> 8;
    if (z < 0) return 0;
    if (z > 256) return 256;
    return int'(z);
  endfunction

  task automatic fill(input int d, input int mode);
    int nin, nsmp, i;
    int w1[4] = '{2047, 2047, -2048, 256};
    int x1[12] = '{255, 255, 255, 0,  0, 0, 0, 128,  0, 0, 0, 255};
    nin  = d ? NI1 : NI0;
    nsmp = d ? NS1 : NS0;
    for (int k = 0; k < nin; k++) begin
      case (mode)
        0: wm[d][k] = int'($urandom_range(0, 4095)) - 2048;
        1: wm[d][k] = int'($urandom_range(0, 127)) - 64;
        2: wm[d][k] = 256;
        3: wm[d][k] = -256;
        4: wm[d][k] = 2047;
        5: wm[d][k] = -2048;
        default: wm[d][k] = w1[k % 4];
      endcase
    end
    for (int k = 0; k < nin * nsmp; k++) begin
      i = k % nin;
      case (mode)
        0, 1:    xm[d][k] = int'($urandom_range(0, 255));
        2:       xm[d][k] = 128;
        3:       xm[d][k] = (i < 2) ? 128 : 0;
        4, 5:    xm[d][k] = 255;
        default: xm[d][k] = x1[k % 12];
      endcase
    end
  endtask

  task automatic chk_reset(input int d);
    chk("rst_busy", int'(bsy[d]), 0);
    chk("rst_done", int'(dn[d]), 0);
    chk("rst_y_valid", int'(yv[d]), 0);
    chk("rst_x_rd", int'(xrd[d]), 0);
    chk("rst_y_data", int'(yd[d]), 0);
    chk("rst_y_idx", int'(yi[d]), 0);
  endtask

  // One run; bp adds 10 stalled cycles per output, rst_at resets mid-FETCH.
  task automatic run(input int d, input int mode, input bit bp, input int rst_at);
    int nin, nsmp, cyc, t_rd, ey;
    logic [9:0] hold_d;
    nin  = d ? NI1 : NI0;
    nsmp = d ? NS1 : NS0;
    fill(d, mode);
    @(negedge clk); start_s[d] = 1'b1;
    @(negedge clk); start_s[d] = 1'b0;
    chk("busy_after_start", int'(bsy[d]), 1);
    for (int c = 0; c < nsmp; c++) begin
      if (c == rst_at) begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk_reset(d);
        @(negedge clk); rst = 1'b0;
        return;
      end
      cyc = 0; t_rd = -1;
      while (!yv[d] && cyc < 100) begin
        if (xrd[d] && t_rd < 0) t_rd = cyc;
        @(negedge clk); cyc++;
      end
      chk("latency", cyc - t_rd, nin + 2);
      ey = model_y(d, c);
      chk("y_data", int'(yd[d]), ey);
      chk("y_idx", int'(yi[d]), c);
      if (bp) begin
        hold_d = yd[d];
        start_s[d] = 1'b1;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("bp_valid", int'(yv[d]), 1);
          chk("bp_data", int'(yd[d]), int'(hold_d));
          chk("bp_idx", int'(yi[d]), c);
          chk("bp_no_rd", int'(xrd[d]), 0);
        end
        start_s[d] = 1'b0;
      end
      rdy_s[d] = 1'b1;
      @(negedge clk); rdy_s[d] = 1'b0;
    end
    chk("done_after_xfer", int'(dn[d]), 1);
    chk("busy_in_done", int'(bsy[d]), 0);
    chk("valid_in_done", int'(yv[d]), 0);
    start_s[d] = 1'b1;
    @(negedge clk); start_s[d] = 1'b0;
    chk("done_one_cycle", int'(dn[d]), 0);
    chk("start_in_done_ignored", int'(bsy[d]), 0);
  endtask

  initial begin
    rst = 1'b1;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    rdy_s[0] = 1'b0;   rdy_s[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst = 1'b0;

    run(0, 2, 1'b0, -1);   // positive mid-curve
    run(0, 3, 1'b0, -1);   // z = -1.0, negative branch
    run(0, 4, 1'b0, -1);   // far positive -> 256
    run(0, 5, 1'b0, -1);   // far negative -> 0
    run(0, 1, 1'b1, -1);   // backpressure + start while busy
    run(0, 1, 1'b0, 3);    // reset mid-FETCH of sample 3
    run(0, 1, 1'b0, -1);   // full run after reset
    for (int r = 0; r < 4; r++) run(0, 1, 1'b0, -1);
    run(0, 0, 1'b0, -1);

    run(1, 6, 1'b1, -1);   // sticky saturation, 0.5 -> 128, 255 boundary
    for (int r = 0; r < 4; r++) run(1, 1, 1'b0, -1);
    run(1, 0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
